// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch conditions and forward selects.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_REM  = 4'd12
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_EQ  = 3'b000,
        COND_NE  = 3'b001,
        COND_LT  = 3'b100,
        COND_GE  = 3'b101,
        COND_LTU = 3'b110,
        COND_GEU = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Iteration counter width must hold the value XLEN itself.
    function automatic int div_cnt_w(input int xlen);
        return $clog2(xlen + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(32);

endpackage

// File: rtl/stage_execute_mdu_div_iter.sv
// Iterative signed divider: restoring radix-2 on magnitudes, one quotient bit per cycle.
// State | meaning: IDLE waiting for start | RUN XLEN iterations | DONE signed result valid.
module div_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic signed [XLEN-1:0] a_i,
    input  logic signed [XLEN-1:0] b_i,
    input  logic                   is_rem_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [XLEN-1:0]        result_o
);
    localparam int CW = div_cnt_w(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic            is_rem_q, is_rem_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [XLEN-1:0] a_u, b_u;
    logic [XLEN:0]   rem_sh, rem_sub;
    logic            ge;

    assign a_u     = a_i;
    assign b_u     = b_i;
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    // The shifted partial remainder stays below 2^XLEN, so the borrow bit is an exact compare.
    assign ge      = ~rem_sub[XLEN];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    quo_d    = a_u[XLEN-1] ? -a_u : a_u;
                    dvs_d    = b_u[XLEN-1] ? -b_u : b_u;
                    rem_d    = '0;
                    is_rem_d = is_rem_i;
                    // Divide by zero keeps the all-ones magnitude unsigned.
                    q_neg_d  = (a_u[XLEN-1] ^ b_u[XLEN-1]) & (b_u != '0);
                    r_neg_d  = a_u[XLEN-1];
                    cnt_d    = CW'(XLEN);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                quo_d = {quo_q[XLEN-2:0], ge};
                rem_d = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = is_rem_q ? (r_neg_q ? -rem_q : rem_q)
                               : (q_neg_q ? -quo_q : quo_q);

endmodule

// File: rtl/stage_execute_mdu.sv
// Execute stage with forwarding, branch resolution, EX/MEM register and optional divider.
// Define STAGE_EXECUTE_DIV_EN to build the multi-cycle DIV/REM unit; otherwise DIV/REM give 0.
module stage_execute_mdu
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic               ex_reg_write,
    input  logic               ex_mem_write,
    input  logic               ex_jump,
    input  logic               ex_jump_cond,
    input  logic [2:0]         ex_jump_cond_type,
    input  logic [3:0]         ex_alu_control,
    input  logic               ex_alu_src,
    input  logic [1:0]         ex_result_src,
    input  logic [XLEN-1:0]    ex_pc,
    input  logic [XLEN-1:0]    ex_pc_plus_4,
    input  logic [XLEN-1:0]    ex_imm_ext,
    input  logic [XLEN-1:0]    ex_rd1,
    input  logic [XLEN-1:0]    ex_rd2,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    wb_result,
    input  logic [1:0]         forward_op1,
    input  logic [1:0]         forward_op2,
    input  logic               ex_flush,
    output logic               mem_reg_write,
    output logic               mem_mem_write,
    output logic [1:0]         mem_result_src,
    output logic [XLEN-1:0]    mem_alu_result,
    output logic [XLEN-1:0]    mem_write_data,
    output logic [XLEN-1:0]    mem_pc_plus_4,
    output logic [XLEN-1:0]    mem_imm_ext,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               ex_pc_src,
    output logic [XLEN-1:0]    ex_pc_target,
    output logic               ex_stall
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]    op1, op2_fwd, op2, alu_res, div_res;
    logic [SHW-1:0]     shamt;
    logic               cond_true, bubble;
    logic               reg_write_q, mem_write_q;
    logic [1:0]         result_src_q;
    logic [XLEN-1:0]    alu_result_q, write_data_q, pc_plus_4_q, imm_ext_q;
    logic [RADDR_W-1:0] rd_q;

    always_comb begin
        case (forward_op1)
            FWD_WB:  op1 = wb_result;
            FWD_MEM: op1 = alu_result_q;
            default: op1 = ex_rd1;
        endcase
        case (forward_op2)
            FWD_WB:  op2_fwd = wb_result;
            FWD_MEM: op2_fwd = alu_result_q;
            default: op2_fwd = ex_rd2;
        endcase
    end

    assign op2   = ex_alu_src ? ex_imm_ext : op2_fwd;
    assign shamt = op2[SHW-1:0];

    always_comb begin
        case (ex_alu_control)
            ALU_ADD:          alu_res = op1 + op2;
            ALU_SUB:          alu_res = op1 - op2;
            ALU_AND:          alu_res = op1 & op2;
            ALU_OR:           alu_res = op1 | op2;
            ALU_XOR:          alu_res = op1 ^ op2;
            ALU_SLT:          alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU:         alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_SLL:          alu_res = op1 << shamt;
            ALU_SRL:          alu_res = op1 >> shamt;
            ALU_SRA:          alu_res = $signed(op1) >>> shamt;
            ALU_MUL:          alu_res = op1 * op2;
            ALU_DIV, ALU_REM: alu_res = div_res;
            default:          alu_res = '0;
        endcase
    end

    // Branches compare the two register operands, never the immediate.
    always_comb begin
        case (ex_jump_cond_type)
            COND_EQ:  cond_true = (op1 == op2_fwd);
            COND_NE:  cond_true = (op1 != op2_fwd);
            COND_LT:  cond_true = ($signed(op1) < $signed(op2_fwd));
            COND_GE:  cond_true = ($signed(op1) >= $signed(op2_fwd));
            COND_LTU: cond_true = (op1 < op2_fwd);
            COND_GEU: cond_true = (op1 >= op2_fwd);
            default:  cond_true = 1'b0;
        endcase
    end

    assign ex_pc_target = ex_pc + ex_imm_ext;
    assign ex_pc_src    = ex_valid & (ex_jump | (ex_jump_cond & cond_true));

`ifdef STAGE_EXECUTE_DIV_EN
    logic div_req, div_busy, div_done;

    assign div_req = ex_valid & ((ex_alu_control == ALU_DIV) | (ex_alu_control == ALU_REM));

    div_iter #(.XLEN(XLEN)) u_div_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (div_req),
        .a_i      (op1),
        .b_i      (op2),
        .is_rem_i (ex_alu_control == ALU_REM),
        .abort_i  (ex_flush),
        .busy_o   (div_busy),
        .done_o   (div_done),
        .result_o (div_res)
    );

    assign ex_stall = div_req & ~ex_flush & ~(div_busy & div_done);
`else
    assign div_res  = '0;
    assign ex_stall = 1'b0;
`endif

    assign bubble = ~ex_valid | ex_flush | ex_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus_4_q  <= '0;
            imm_ext_q    <= '0;
            rd_q         <= '0;
        end else if (bubble) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus_4_q  <= '0;
            imm_ext_q    <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= ex_reg_write;
            mem_write_q  <= ex_mem_write;
            result_src_q <= ex_result_src;
            alu_result_q <= alu_res;
            write_data_q <= op2_fwd;
            pc_plus_4_q  <= ex_pc_plus_4;
            imm_ext_q    <= ex_imm_ext;
            rd_q         <= ex_rd;
        end
    end

    assign mem_reg_write  = reg_write_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_result_src = result_src_q;
    assign mem_alu_result = alu_result_q;
    assign mem_write_data = write_data_q;
    assign mem_pc_plus_4  = pc_plus_4_q;
    assign mem_imm_ext    = imm_ext_q;
    assign mem_rd         = rd_q;

endmodule

// File: tb/tb_stage_execute_mdu.sv
// Bench for stage_execute_mdu: directed literal cases plus randomized traffic against a behavioural model.
module tb_stage_execute_mdu;

`ifdef STAGE_EXECUTE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_reg_write, ex_mem_write, ex_jump, ex_jump_cond;
    logic [2:0]  ex_jump_cond_type;
    logic [3:0]  ex_alu_control;
    logic        ex_alu_src;
    logic [1:0]  ex_result_src;
    logic [31:0] ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2, wb_result;
    logic [4:0]  ex_rd;
    logic [1:0]  forward_op1, forward_op2;
    logic        ex_flush;
    logic        mem_reg_write, mem_mem_write;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext;
    logic [4:0]  mem_rd;
    logic        ex_pc_src, ex_stall;
    logic [31:0] ex_pc_target;

    stage_execute_mdu #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_jump(ex_jump), .ex_jump_cond(ex_jump_cond),
        .ex_jump_cond_type(ex_jump_cond_type), .ex_alu_control(ex_alu_control),
        .ex_alu_src(ex_alu_src), .ex_result_src(ex_result_src), .ex_pc(ex_pc),
        .ex_pc_plus_4(ex_pc_plus_4), .ex_imm_ext(ex_imm_ext), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_rd(ex_rd), .wb_result(wb_result), .forward_op1(forward_op1),
        .forward_op2(forward_op2), .ex_flush(ex_flush), .mem_reg_write(mem_reg_write),
        .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_pc_plus_4(mem_pc_plus_4), .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
        .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target), .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw;
        logic [1:0]  rs;
        logic [31:0] alu, wd, pc4, imm;
        logic [4:0]  rd;
    } mem_t;

    int          checks = 0, failures = 0;
    bit          chk_en = 1'b0;
    mem_t        exp_reg = '0;
    logic        exp_stall = 1'b0, exp_pc_src = 1'b0;
    logic [31:0] exp_target = '0;
    int          age = 0;
    logic [31:0] lat_a = '0, lat_b = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return wb_result;
        if (sel == 2'b10) return exp_reg.alu;
        return rf;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return $signed(a) >>> b[4:0];
            4'd10: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b, input bit rem);
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
        return rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    endfunction

    function automatic bit cond_model(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        case (t)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One pipeline cycle with the current inputs: predict outputs, advance through the clock edge.
    task automatic issue();
        mem_t        n;
        logic [31:0] a, bf, b;
        bit          divop, req, stl;
        #1;
        a  = fwd(forward_op1, ex_rd1);
        bf = fwd(forward_op2, ex_rd2);
        b  = ex_alu_src ? ex_imm_ext : bf;
        divop = DIV_EN && (ex_alu_control == 4'd11 || ex_alu_control == 4'd12);
        req   = ex_valid && divop;
        if (req && !ex_flush && age == 0) begin
            lat_a = a;
            lat_b = b;
        end
        stl        = req && !ex_flush && (age <= XLEN);
        exp_stall  = stl;
        exp_pc_src = ex_valid && (ex_jump || (ex_jump_cond && cond_model(ex_jump_cond_type, a, bf)));
        exp_target = ex_pc + ex_imm_ext;
        n = '0;
        if (ex_valid && !ex_flush && !stl) begin
            n.rw  = ex_reg_write;
            n.mw  = ex_mem_write;
            n.rs  = ex_result_src;
            n.alu = divop ? div_model(lat_a, lat_b, ex_alu_control == 4'd12)
                          : alu_model(ex_alu_control, a, b);
            n.wd  = bf;
            n.pc4 = ex_pc_plus_4;
            n.imm = ex_imm_ext;
            n.rd  = ex_rd;
        end
        @(posedge clk);
        #1;
        exp_reg = n;
        age = stl ? age + 1 : 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", ex_stall, exp_stall);
            chk("pc_src", ex_pc_src, exp_pc_src);
            chk("pc_target", ex_pc_target, exp_target);
            chk("reg_write", mem_reg_write, exp_reg.rw);
            chk("mem_write", mem_mem_write, exp_reg.mw);
            chk("result_src", mem_result_src, exp_reg.rs);
            chk("alu_result", mem_alu_result, exp_reg.alu);
            chk("write_data", mem_write_data, exp_reg.wd);
            chk("pc_plus_4", mem_pc_plus_4, exp_reg.pc4);
            chk("imm_ext", mem_imm_ext, exp_reg.imm);
            chk("rd", mem_rd, exp_reg.rd);
        end
    end

    task automatic set_nop();
        ex_valid = 0; ex_reg_write = 0; ex_mem_write = 0; ex_jump = 0; ex_jump_cond = 0;
        ex_jump_cond_type = 0; ex_alu_control = 0; ex_alu_src = 0; ex_result_src = 0;
        ex_pc = 0; ex_pc_plus_4 = 0; ex_imm_ext = 0; ex_rd1 = 0; ex_rd2 = 0; ex_rd = 0;
        wb_result = 0; forward_op1 = 0; forward_op2 = 0; ex_flush = 0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        set_nop();
        ex_valid = 1; ex_reg_write = 1; ex_alu_control = op; ex_rd1 = a; ex_rd2 = b;
        ex_rd = 5'd7; ex_pc_plus_4 = 32'h204;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Runs a divide in EX until the stall clears and retires it; returns stall cycle count.
    task automatic run_div(output int n);
        n = 0;
        #1;
        while (ex_stall && n < 100) begin
            if (n > 0) begin
                ex_rd1 = $urandom;
                wb_result = $urandom;
            end
            issue();
            n++;
        end
        issue();
    endtask

    task automatic model_reset();
        exp_reg = '0; age = 0; exp_stall = 0; exp_pc_src = 0; exp_target = 0;
    endtask

    initial begin
        int n;
        #200_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        set_nop();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_alu", mem_alu_result, 0);
        chk("reset_ctl", {mem_reg_write, mem_mem_write, mem_result_src, mem_rd}, 0);
        chk("reset_stall", ex_stall, 0);
        chk("reset_pc_src", ex_pc_src, 0);
        issue();

        set_op(4'd0, 32'd3, 32'd4);
        issue();
        chk("add_3_4", mem_alu_result, 32'd7);
        set_op(4'd0, 32'd999, 32'd5);
        forward_op1 = 2'b10;
        issue();
        chk("add_fwd_mem", mem_alu_result, 32'd12);

        set_op(4'd0, 32'hFFFF_FFFD, 32'd2);
        ex_jump_cond = 1; ex_jump_cond_type = 3'b100; ex_imm_ext = 32'd16; ex_pc = 32'h100;
        #1;
        chk("blt_taken", ex_pc_src, 1);
        chk("blt_target", ex_pc_target, 32'h110);
        ex_valid = 0;
        #1;
        chk("blt_bubble", ex_pc_src, 0);
        issue();

        set_op(4'd11, 32'hFFFF_FFEC, 32'd3);
        run_div(n);
        chk("div_stall_cycles", n, DIV_EN ? 33 : 0);
        chk("div_m20_3", mem_alu_result, DIV_EN ? 32'hFFFF_FFFA : 32'd0);
        set_op(4'd12, 32'hFFFF_FFEC, 32'd3);
        run_div(n);
        chk("rem_m20_3", mem_alu_result, DIV_EN ? 32'hFFFF_FFFE : 32'd0);
        set_op(4'd11, 32'd5, 32'd0);
        run_div(n);
        chk("div_by_zero", mem_alu_result, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
        set_op(4'd12, 32'd5, 32'd0);
        run_div(n);
        chk("rem_by_zero", mem_alu_result, DIV_EN ? 32'd5 : 32'd0);
        set_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(n);
        chk("div_overflow", mem_alu_result, DIV_EN ? 32'h8000_0000 : 32'd0);

        set_op(4'd11, 32'd100, 32'd7);
        repeat (9) issue();
        ex_flush = 1;
        #1;
        chk("flush_stall_drop", ex_stall, 0);
        issue();
        chk("flush_bubble", mem_reg_write, 0);
        set_op(4'd0, 32'd1, 32'd2);
        issue();
        chk("add_after_flush", mem_alu_result, 32'd3);

        set_op(4'd11, 32'd1000, 32'd9);
        repeat (5) issue();
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_alu", mem_alu_result, 0);
        chk("rst_mid_ctl", {mem_reg_write, mem_mem_write, mem_result_src, mem_rd}, 0);
        chk("rst_mid_data", mem_write_data | mem_pc_plus_4 | mem_imm_ext, 0);
        model_reset();
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_mid_stall", ex_stall, 0);
        issue();

        for (int i = 0; i < 400; i++) begin
            if (age == 0) begin
                ex_valid          = ($urandom % 8) != 0;
                ex_reg_write      = $urandom;
                ex_mem_write      = $urandom;
                ex_jump           = ($urandom % 6) == 0;
                ex_jump_cond      = ($urandom % 3) == 0;
                ex_jump_cond_type = $urandom;
                ex_alu_control    = $urandom;
                ex_alu_src        = $urandom;
                if (ex_jump_cond || ex_alu_control == 4'd11 || ex_alu_control == 4'd12)
                    ex_alu_src = 0;
                ex_result_src     = $urandom;
                ex_pc             = $urandom;
                ex_pc_plus_4      = $urandom;
                ex_imm_ext        = rand_val();
                ex_rd             = $urandom;
            end
            ex_rd1      = rand_val();
            ex_rd2      = rand_val();
            wb_result   = rand_val();
            forward_op1 = $urandom;
            forward_op2 = $urandom;
            ex_flush    = ($urandom % 25) == 0;
            issue();
        end
        set_nop();
        issue();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
